screen_sequencer: RTL

// Upstream control for the full-screen pixel drawer (DrawBlack). Sequences the screens:

---
 rtl/screen_sequencer_pkg.sv | 52 +++++
 rtl/screen_sequencer_frame_pass.sv | 58 +++++
 rtl/screen_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/screen_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// screen_pkg
// Shared constants and state encoding for the screen sequencer and its frame
// pass helper. Screen geometry, the two colour codes the drawer uses, and the
// sequencer state enumeration plus small state-class helpers.
// -----------------------------------------------------------------------------
package screen_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int FRAME_PIXELS = SCREEN_W * SCREEN_H;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;

  localparam logic [3:0] ST_CLR_PREP = 4'd0;
  localparam logic [3:0] ST_CLR_DRAW = 4'd1;
  localparam logic [3:0] ST_TTL_PREP = 4'd2;
  localparam logic [3:0] ST_TTL_DRAW = 4'd3;
  localparam logic [3:0] ST_IDLE     = 4'd4;
  localparam logic [3:0] ST_FLS_PREP = 4'd5;
  localparam logic [3:0] ST_FLS_DRAW = 4'd6;
  localparam logic [3:0] ST_GAME     = 4'd7;
  localparam logic [3:0] ST_GO_PREP  = 4'd8;
  localparam logic [3:0] ST_GO_DRAW  = 4'd9;
  localparam logic [3:0] ST_HOLD     = 4'd10;

  typedef enum logic [3:0] {
    CLR_PREP = ST_CLR_PREP,
    CLR_DRAW = ST_CLR_DRAW,
    TTL_PREP = ST_TTL_PREP,
    TTL_DRAW = ST_TTL_DRAW,
    IDLE     = ST_IDLE,
    FLS_PREP = ST_FLS_PREP,
    FLS_DRAW = ST_FLS_DRAW,
    GAME     = ST_GAME,
    GO_PREP  = ST_GO_PREP,
    GO_DRAW  = ST_GO_DRAW,
    HOLD     = ST_HOLD
  } state_t;

  // True in the single realignment cycle that opens every frame pass.
  function automatic logic is_prep(input state_t s);
    return (s == CLR_PREP) || (s == TTL_PREP) || (s == FLS_PREP) || (s == GO_PREP);
  endfunction

  // True while pixels of some screen are being written.
  function automatic logic is_draw(input state_t s);
    return (s == CLR_DRAW) || (s == TTL_DRAW) || (s == FLS_DRAW) || (s == GO_DRAW);
  endfunction

endpackage

// File: rtl/screen_sequencer_frame_pass.sv
// -----------------------------------------------------------------------------
// frame_pass
// Pixel counter shared by every screen. A go cycle (the sequencer's PREP state)
// zeroes the counter and pulses draw_rst_n low; the following NUM_PIXELS cycles
// are the DRAW phase. done flags the last DRAW cycle so the sequencer can move
// on at that edge.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   go          sequencer is in a PREP state
//   draw_rst_n  registered active-low drawer address reset (low one cycle)
//   active      registered DRAW indicator, drives the VGA plot enable
//   done        combinational, high on the last DRAW cycle
// -----------------------------------------------------------------------------
module frame_pass #(
  parameter int NUM_PIXELS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic draw_rst_n,
  output logic active,
  output logic done
);

  localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [PW-1:0] LAST_PIX = PW'(NUM_PIXELS - 1);

  logic          in_draw_r;
  logic [PW-1:0] pix_cnt_r;

  assign done = in_draw_r && (pix_cnt_r == LAST_PIX);

  // PREP/DRAW phase tracking and pixel counter; outputs trail the phase by one
  // clock so they line up with the sequencer's registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_draw_r  <= 1'b0;
      pix_cnt_r  <= '0;
      draw_rst_n <= 1'b1;
      active     <= 1'b0;
    end else begin
      draw_rst_n <= ~go;
      active     <= in_draw_r;
      if (go) begin
        in_draw_r <= 1'b1;
        pix_cnt_r <= '0;
      end else if (done) begin
        in_draw_r <= 1'b0;
        pix_cnt_r <= '0;
      end else if (in_draw_r) begin
        pix_cnt_r <= pix_cnt_r + PW'(1);
      end else begin
        pix_cnt_r <= pix_cnt_r;
      end
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// -----------------------------------------------------------------------------
// screen_sequencer
// Sequences the full-screen drawer: black clear -> title -> idle with periodic
// flash/title redraws -> black clear -> game -> game-over hold -> title.
// Every output is a register loaded from the state being left at each edge, so
// the visible strobes trail state_r by one clock. game_en additionally looks at
// game_over so that it falls on the same edge the game ends.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   start         synchronised start key level (rising edge used)
//   game_over     one-cycle end-of-game pulse, honoured only in GAME
//   showBlack, showTitle, flash, showGameOver   one-hot drawer strobes
//   plot          VGA write enable, high exactly while a strobe is high
//   draw_rst_n    active-low drawer address reset, low one cycle per frame
//   game_en       game logic enable
//   busy          a frame pass (PREP or DRAW) is in progress
// -----------------------------------------------------------------------------
module screen_sequencer #(
  parameter int FRAME_PIXELS = 19200,
  parameter int FLASH_PERIOD = 25000000,
  parameter int HOLD_CYCLES  = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic game_over,
  output logic showBlack,
  output logic showTitle,
  output logic flash,
  output logic showGameOver,
  output logic plot,
  output logic draw_rst_n,
  output logic game_en,
  output logic busy
);

  import screen_pkg::*;

  localparam int FW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

  state_t        state_r;
  logic          start_d_r;
  logic          pending_r;
  logic          flash_phase_r;
  logic [FW-1:0] flash_tmr_r;
  logic [HW-1:0] hold_tmr_r;

  logic start_edge_s;
  logic ttl_fls_s;
  logic pend_s;
  logic go_s;
  logic pass_done_s;

  assign start_edge_s = start && !start_d_r;
  // Start edges are remembered only while a title or flash pass is running.
  assign ttl_fls_s    = (state_r == TTL_PREP) || (state_r == TTL_DRAW) ||
                        (state_r == FLS_PREP) || (state_r == FLS_DRAW);
  assign pend_s       = pending_r || (ttl_fls_s && start_edge_s);
  assign go_s         = is_prep(state_r);

  frame_pass #(
    .NUM_PIXELS(FRAME_PIXELS)
  ) u_pass (
    .clk        (clk),
    .rst        (rst),
    .go         (go_s),
    .draw_rst_n (draw_rst_n),
    .active     (plot),
    .done       (pass_done_s)
  );

  // Screen state machine with timers, start tracking and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= CLR_PREP;
      start_d_r     <= 1'b0;
      pending_r     <= 1'b0;
      flash_phase_r <= 1'b0;
      flash_tmr_r   <= '0;
      hold_tmr_r    <= '0;
      showBlack     <= 1'b0;
      showTitle     <= 1'b0;
      flash         <= 1'b0;
      showGameOver  <= 1'b0;
      game_en       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      start_d_r    <= start;
      showBlack    <= (state_r == CLR_DRAW);
      showTitle    <= (state_r == TTL_DRAW);
      flash        <= (state_r == FLS_DRAW);
      showGameOver <= (state_r == GO_DRAW);
      busy         <= is_prep(state_r) || is_draw(state_r);
      // Drop together with the GAME -> GO_PREP transition, not a clock later.
      game_en      <= (state_r == GAME) && !game_over;

      case (state_r)
        CLR_PREP: state_r <= CLR_DRAW;
        CLR_DRAW: begin
          if (pass_done_s) begin
            if (pending_r) begin
              state_r   <= GAME;
              pending_r <= 1'b0;
            end else begin
              state_r <= TTL_PREP;
            end
          end else begin
            state_r <= CLR_DRAW;
          end
        end
        TTL_PREP: begin
          state_r   <= TTL_DRAW;
          pending_r <= pend_s;
        end
        FLS_PREP: begin
          state_r   <= FLS_DRAW;
          pending_r <= pend_s;
        end
        TTL_DRAW, FLS_DRAW: begin
          pending_r <= pend_s;
          if (pass_done_s) begin
            state_r <= pend_s ? CLR_PREP : IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        IDLE: begin
          // A start edge overrides a flash expiry in the same cycle.
          if (start_edge_s) begin
            state_r       <= CLR_PREP;
            pending_r     <= 1'b1;
            flash_tmr_r   <= '0;
            flash_phase_r <= 1'b0;
          end else if (flash_tmr_r == FLASH_LAST) begin
            state_r       <= flash_phase_r ? TTL_PREP : FLS_PREP;
            flash_tmr_r   <= '0;
            flash_phase_r <= ~flash_phase_r;
          end else begin
            flash_tmr_r <= flash_tmr_r + FW'(1);
          end
        end
        GAME: begin
          if (game_over) begin
            state_r <= GO_PREP;
          end else begin
            state_r <= GAME;
          end
        end
        GO_PREP: state_r <= GO_DRAW;
        GO_DRAW: begin
          if (pass_done_s) begin
            state_r <= HOLD;
          end else begin
            state_r <= GO_DRAW;
          end
        end
        HOLD: begin
          if (hold_tmr_r == HOLD_LAST) begin
            state_r    <= TTL_PREP;
            hold_tmr_r <= '0;
          end else begin
            hold_tmr_r <= hold_tmr_r + HW'(1);
          end
        end
        default: begin
          state_r   <= CLR_PREP;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
